disparo_control: RTL and testbench
==================================

# disparo_control

Attack-phase counterpart of the ship-placement logic. It latches the opponent's finished 5×5 placement matrix and lets the player move a cursor and fire. Each shot is resolved as agua, tocado or hundido, and the block maintains the shot map shown on the display. It sits between the button front-end and the turn/score controller and raises `fin_turno` and `game_over` for the top-level game FSM.

## Interface
Parameters:
- `N`, 5, board dimension (rows = columns = N).
- `SHOTS_TOTAL`, 15, number of ship cells on a full board (5+4+3+2+1).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `izquierda`, `arriba`, `abajo`, `derecha`  in  1 each  single-cycle move pulses, already debounced and edge-detected.
- `disparar`  in  1  single-cycle fire pulse.
- `en_disparo`  in  1  level; high while it is this player's turn.
- `cargar`  in  1  single-cycle pulse; latch `matriz_enemigo` and start a new game.
- `matriz_enemigo`  in  [3:0] [N-1:0][N-1:0]  placement board.
  - 0 = water; 1..5 = ship id, which equals the ship length.
  - 6..15 = treated as water.
- `matriz_disparos`  out  [3:0] [N-1:0][N-1:0]  shot map: 0 = not shot, 6 = agua, 7 = tocado.
- `posicion_x`, `posicion_y`  out  [2:0] each  cursor position.
- `resultado`  out  [1:0]  last shot result: 00 none, 01 agua, 10 tocado, 11 hundido.
- `barco_hundido`  out  [2:0]  id of the last ship sunk; 0 if none.
- `disparo_valido`  out  1  one-cycle pulse when `resultado` updates.
- `disparo_repetido`  out  1  one-cycle pulse when fire is aimed at an already-shot cell.
- `fin_turno`  out  1  one-cycle pulse; the turn passes to the opponent.
- `game_over`  out  1  level; all ship cells have been hit.

## Operation
States: IDLE, APUNTAR, EVALUAR, ESPERA, FIN.

IDLE:
- Ignores all buttons.
- `cargar` latches the board, clears the shot map, and loads per-ship counters `restante[id] = id` and `total = SHOTS_TOTAL`.
- Cursor goes to (4,4); next state is APUNTAR.

APUNTAR (inputs acted on only while `en_disparo` = 1):
- `arriba`: y+1, saturating at N-1. `abajo`: y-1, saturating at 0.
- `izquierda`: x+1, saturating at N-1. `derecha`: x-1, saturating at 0.
- `arriba` and `abajo` in the same cycle: y unchanged. `izquierda` and `derecha` in the same cycle: x unchanged. x and y update independently.
- `disparar` takes priority: movement pulses in the same cycle are ignored.
  - If the target cell ≠ 0 in `matriz_disparos`: pulse `disparo_repetido`, stay in APUNTAR, leave `resultado` unchanged.
  - Otherwise capture (x,y) and go to EVALUAR.

EVALUAR (one cycle). Let v = the latched cell at (x,y).
- v = 0 or v > 5 (agua): mark the cell 6, set `resultado` = 01, pulse `fin_turno`, go to ESPERA.
- v in 1..5 (tocado): mark the cell 7, decrement `restante[v]` and `total`.
  - If `restante[v]` reaches 0: `resultado` = 11 and `barco_hundido` = v. Otherwise `resultado` = 10.
  - If `total` reaches 0: go to FIN. Otherwise go back to APUNTAR; a hit keeps the turn.
- `disparo_valido` pulses in the cycle `resultado` updates.

ESPERA:
- Waits for `en_disparo` = 0, then returns to APUNTAR.
- Buttons are ignored.

FIN:
- `game_over` = 1 and stays high.
- Buttons are ignored.
- Only `cargar` or reset leaves this state.

`cargar` in any state other than IDLE behaves exactly as in IDLE: new game, `resultado` = 00, `barco_hundido` = 0, next state APUNTAR.

Counters: `restante` is 3 bits per ship; `total` is 4 bits. Neither ever decrements below 0, because shot cells are never re-evaluated.

## Timing
Reset values:
- State IDLE; shot map all 0; cursor (4,4).
- `resultado` = 00, `barco_hundido` = 0.
- All pulses 0; `game_over` = 0; counters 0.

Latencies:
- Move: cursor output changes the cycle after the pulse.
- Fire at cycle t:
  - EVALUAR at t+1.
  - `resultado`, shot-map update, `disparo_valido`, and `fin_turno` (agua only) are all registered and visible at t+2.
  - `game_over` is high from t+2 on the last hit.
- `disparo_repetido` is visible at t+1.
- A fire pulse arriving while in EVALUAR, ESPERA or FIN is dropped.
- Asynchronous reset mid-shot aborts the shot. Nothing is recorded, and all outputs take their reset values immediately.

## Test plan
- Reset, then `cargar` a board with ship 1 at (0,0). Press `derecha`×4 and `abajo`×4 → cursor (0,0). Fire → at t+2: `resultado` = 11, `barco_hundido` = 1, cell(0,0) = 7, `fin_turno` = 0.
- Fire at water at (4,4) → `resultado` = 01, cell = 6, `fin_turno` pulses once. State stays in ESPERA until `en_disparo` drops, and moves are ignored there.
- Fire twice at the same hit cell → second fire gives `disparo_repetido` at t+1, with no change to `resultado` or counters.
- Saturation: `arriba`×3 at y = 4 → y stays 4. `izquierda` and `derecha` in the same cycle → x unchanged. `disparar` together with `abajo` → shot at the original y.
- Ship 5 in row 2: hit 4 of its cells → `resultado` = 10 each time. Hit the 5th cell → 11 with `barco_hundido` = 5. Hit all 15 ship cells → `game_over` = 1, and further fires are ignored.
- Assert `rst_n` low at the cycle the FSM is in EVALUAR → no cell marked, all outputs at reset values. After `cargar`, the game restarts cleanly.

Source files
------------

// File: rtl/disparo_control.sv
// Attack-phase controller: latches the opponent's placement board, steers the
// cursor, resolves each shot as agua/tocado/hundido and maintains the shot map.
module disparo_control #(
    parameter int N           = 5,
    parameter int SHOTS_TOTAL = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     izquierda,
    input  logic                     arriba,
    input  logic                     abajo,
    input  logic                     derecha,
    input  logic                     disparar,
    input  logic                     en_disparo,
    input  logic                     cargar,
    input  logic [N-1:0][N-1:0][3:0] matriz_enemigo,
    output logic [N-1:0][N-1:0][3:0] matriz_disparos,
    output logic [2:0]               posicion_x,
    output logic [2:0]               posicion_y,
    output logic [1:0]               resultado,
    output logic [2:0]               barco_hundido,
    output logic                     disparo_valido,
    output logic                     disparo_repetido,
    output logic                     fin_turno,
    output logic                     game_over
);

    localparam int         NUM_BARCOS   = 5;
    localparam logic [3:0] CELDA_AGUA   = 4'd6;
    localparam logic [3:0] CELDA_TOCADO = 4'd7;
    localparam logic [2:0] POS_MAX      = 3'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        APUNTAR,
        EVALUAR,
        ESPERA,
        FIN
    } estado_t;

    typedef enum logic [1:0] {
        RES_NINGUNO = 2'b00,
        RES_AGUA    = 2'b01,
        RES_TOCADO  = 2'b10,
        RES_HUNDIDO = 2'b11
    } resultado_t;

    estado_t                  estado;
    estado_t                  estado_d;
    logic [N-1:0][N-1:0][3:0] tablero;
    logic [2:0]               obj_x;
    logic [2:0]               obj_y;
    logic [2:0]               restante [1:NUM_BARCOS];
    logic [3:0]               total;

    // Strobes decoded by the FSM and consumed by the datapath register block.
    logic       carga;
    logic       mover;
    logic       fijar_objetivo;
    logic       repetido;
    logic       evaluar;

    logic [3:0] valor;
    logic [2:0] id_barco;
    logic       es_tocado;
    logic       ultimo_del_barco;
    logic       ultimo_total;

    // Saturating one-step move; opposing pulses in the same cycle cancel.
    function automatic logic [2:0] paso(input logic [2:0] p, input logic inc, input logic dec);
        if (inc && !dec && (p != POS_MAX)) return p + 3'd1;
        if (dec && !inc && (p != 3'd0))    return p - 3'd1;
        return p;
    endfunction

    assign valor            = tablero[obj_y][obj_x];
    assign id_barco         = valor[2:0];
    assign es_tocado        = (valor != 4'd0) && (valor <= 4'(NUM_BARCOS));
    assign ultimo_del_barco = es_tocado && (restante[id_barco] == 3'd1);
    assign ultimo_total     = (total == 4'd1);
    assign game_over        = (estado == FIN);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= estado_d;
    end

    // NOTE: every signal driven here gets a default first; a path that skipped
    // one would turn it into a latch.
    always_comb begin
        estado_d       = estado;
        carga          = 1'b0;
        mover          = 1'b0;
        fijar_objetivo = 1'b0;
        repetido       = 1'b0;
        evaluar        = 1'b0;

        if (cargar) begin
            carga    = 1'b1;
            estado_d = APUNTAR;
        end else begin
            case (estado)
                IDLE: ;
                APUNTAR: begin
                    if (en_disparo) begin
                        if (disparar) begin
                            if (matriz_disparos[posicion_y][posicion_x] != 4'd0) begin
                                repetido = 1'b1;
                            end else begin
                                fijar_objetivo = 1'b1;
                                estado_d       = EVALUAR;
                            end
                        end else begin
                            mover = 1'b1;
                        end
                    end
                end
                EVALUAR: begin
                    evaluar = 1'b1;
                    if (!es_tocado)        estado_d = ESPERA;
                    else if (ultimo_total) estado_d = FIN;
                    else                   estado_d = APUNTAR;
                end
                ESPERA: begin
                    if (!en_disparo) estado_d = APUNTAR;
                end
                FIN: ;
                default: estado_d = IDLE;
            endcase
        end
    end

    // NOTE: the latched board, shot map and ship counters are reset explicitly
    // so a reset mid-game can never leak stale marks onto the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tablero          <= '0;
            matriz_disparos  <= '0;
            posicion_x       <= POS_MAX;
            posicion_y       <= POS_MAX;
            obj_x            <= '0;
            obj_y            <= '0;
            resultado        <= RES_NINGUNO;
            barco_hundido    <= 3'd0;
            disparo_valido   <= 1'b0;
            disparo_repetido <= 1'b0;
            fin_turno        <= 1'b0;
            total            <= 4'd0;
            for (int id = 1; id <= NUM_BARCOS; id++) restante[id] <= 3'd0;
        end else begin
            disparo_valido   <= 1'b0;
            disparo_repetido <= 1'b0;
            fin_turno        <= 1'b0;

            if (carga) begin
                tablero         <= matriz_enemigo;
                matriz_disparos <= '0;
                posicion_x      <= POS_MAX;
                posicion_y      <= POS_MAX;
                resultado       <= RES_NINGUNO;
                barco_hundido   <= 3'd0;
                total           <= 4'(SHOTS_TOTAL);
                for (int id = 1; id <= NUM_BARCOS; id++) restante[id] <= 3'(id);
            end else begin
                if (mover) begin
                    posicion_x <= paso(posicion_x, izquierda, derecha);
                    posicion_y <= paso(posicion_y, arriba, abajo);
                end

                if (repetido) disparo_repetido <= 1'b1;

                if (fijar_objetivo) begin
                    obj_x <= posicion_x;
                    obj_y <= posicion_y;
                end

                if (evaluar) begin
                    disparo_valido <= 1'b1;
                    if (es_tocado) begin
                        matriz_disparos[obj_y][obj_x] <= CELDA_TOCADO;
                        if (restante[id_barco] != 3'd0) restante[id_barco] <= restante[id_barco] - 3'd1;
                        if (total != 4'd0)              total <= total - 4'd1;
                        if (ultimo_del_barco) begin
                            resultado     <= RES_HUNDIDO;
                            barco_hundido <= id_barco;
                        end else begin
                            resultado <= RES_TOCADO;
                        end
                    end else begin
                        // Values 0 and 6..15 on the board are all water.
                        matriz_disparos[obj_y][obj_x] <= CELDA_AGUA;
                        resultado                     <= RES_AGUA;
                        fin_turno                     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_disparo_control.sv
// Bench for disparo_control: directed game on a fixed board, reset during a
// shot, then random boards and random play against a rule-level game model.
module tb_disparo_control;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 izquierda, arriba, abajo, derecha;
    logic                 disparar, en_disparo, cargar;
    logic [4:0][4:0][3:0] matriz_enemigo;
    logic [4:0][4:0][3:0] matriz_disparos;
    logic [2:0]           posicion_x, posicion_y;
    logic [1:0]           resultado;
    logic [2:0]           barco_hundido;
    logic                 disparo_valido, disparo_repetido, fin_turno, game_over;

    disparo_control dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .izquierda        (izquierda),
        .arriba           (arriba),
        .abajo            (abajo),
        .derecha          (derecha),
        .disparar         (disparar),
        .en_disparo       (en_disparo),
        .cargar           (cargar),
        .matriz_enemigo   (matriz_enemigo),
        .matriz_disparos  (matriz_disparos),
        .posicion_x       (posicion_x),
        .posicion_y       (posicion_y),
        .resultado        (resultado),
        .barco_hundido    (barco_hundido),
        .disparo_valido   (disparo_valido),
        .disparo_repetido (disparo_repetido),
        .fin_turno        (fin_turno),
        .game_over        (game_over)
    );

    always #5 clk = ~clk;

    // Game model: board contents, shot marks, cursor and turn phase.
    typedef enum {M_IDLE, M_APUNTAR, M_ESPERA, M_FIN} modo_t;

    int    brd  [5][5];
    int    shot [5][5];
    int    mx, my;
    int    m_res, m_barco;
    modo_t m_modo;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mapa(input string tag);
        logic [4:0][4:0][3:0] em;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) em[y][x] = 4'(shot[y][x]);
        n_tests++;
        assert (matriz_disparos === em) else begin
            n_fail++;
            $error("FAIL %s: observed map %0h expected map %0h", tag, matriz_disparos, em);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    function automatic bit es_barco(input int v);
        return (v >= 1) && (v <= 5);
    endfunction

    function automatic int sin_tocar(input int id);
        int c = 0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                if (shot[y][x] == 0 && ((id == 0) ? es_barco(brd[y][x]) : (brd[y][x] == id))) c++;
        return c;
    endfunction

    task automatic modelo_reset();
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) shot[y][x] = 0;
        mx = 4; my = 4; m_res = 0; m_barco = 0; m_modo = M_IDLE;
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "/x"}, 32'(posicion_x), 32'(mx));
        check({tag, "/y"}, 32'(posicion_y), 32'(my));
    endtask

    task automatic mover(input bit izq, input bit arr, input bit abj, input bit der);
        bit activo;
        activo    = (m_modo == M_APUNTAR) && en_disparo;
        izquierda = izq; arriba = arr; abajo = abj; derecha = der;
        ciclo();
        izquierda = 0; arriba = 0; abajo = 0; derecha = 0;
        if (activo) begin
            if (izq && !der) mx = (mx < 4) ? mx + 1 : 4;
            if (der && !izq) mx = (mx > 0) ? mx - 1 : 0;
            if (arr && !abj) my = (my < 4) ? my + 1 : 4;
            if (abj && !arr) my = (my > 0) ? my - 1 : 0;
        end
        check_cursor("mover");
    endtask

    task automatic ir_a(input int tx, input int ty);
        for (int k = 0; k < 5 && mx < tx; k++) mover(1, 0, 0, 0);
        for (int k = 0; k < 5 && mx > tx; k++) mover(0, 0, 0, 1);
        for (int k = 0; k < 5 && my < ty; k++) mover(0, 1, 0, 0);
        for (int k = 0; k < 5 && my > ty; k++) mover(0, 0, 1, 0);
    endtask

    task automatic disparo(input string tag, input bit izq = 1'b0, input bit arr = 1'b0,
                           input bit abj = 1'b0, input bit der = 1'b0);
        bit activo, exp_fin;
        int v;
        activo    = (m_modo == M_APUNTAR) && en_disparo;
        disparar  = 1; izquierda = izq; arriba = arr; abajo = abj; derecha = der;
        ciclo();
        disparar  = 0; izquierda = 0; arriba = 0; abajo = 0; derecha = 0;
        if (activo && shot[my][mx] != 0) begin
            check({tag, "/repetido"}, 32'(disparo_repetido), 32'd1);
            check({tag, "/res_rep"}, 32'(resultado), 32'(m_res));
            ciclo();
            check({tag, "/valido_rep"}, 32'(disparo_valido), 32'd0);
            check_mapa({tag, "/mapa_rep"});
        end else if (activo) begin
            check({tag, "/no_rep"}, 32'(disparo_repetido), 32'd0);
            ciclo();
            v = brd[my][mx];
            if (es_barco(v)) begin
                shot[my][mx] = 7;
                if (sin_tocar(v) == 0) begin
                    m_res = 3; m_barco = v;
                end else begin
                    m_res = 2;
                end
                m_modo  = (sin_tocar(0) == 0) ? M_FIN : M_APUNTAR;
                exp_fin = 0;
            end else begin
                shot[my][mx] = 6;
                m_res   = 1;
                m_modo  = M_ESPERA;
                exp_fin = 1;
            end
            check({tag, "/valido"}, 32'(disparo_valido), 32'd1);
            check({tag, "/fin_turno"}, 32'(fin_turno), 32'(exp_fin));
            check({tag, "/res"}, 32'(resultado), 32'(m_res));
            check({tag, "/barco"}, 32'(barco_hundido), 32'(m_barco));
            check({tag, "/game_over"}, 32'(game_over), 32'(m_modo == M_FIN));
            check_mapa({tag, "/mapa"});
            check_cursor(tag);
            ciclo();
            check({tag, "/valido_1c"}, 32'(disparo_valido), 32'd0);
            check({tag, "/fin_turno_1c"}, 32'(fin_turno), 32'd0);
        end else begin
            check({tag, "/drop_rep"}, 32'(disparo_repetido), 32'd0);
            ciclo();
            check({tag, "/drop_valido"}, 32'(disparo_valido), 32'd0);
            check({tag, "/drop_res"}, 32'(resultado), 32'(m_res));
            check_mapa({tag, "/drop_mapa"});
            check_cursor(tag);
        end
    endtask

    task automatic ceder_turno();
        en_disparo = 0;
        ciclo();
        if (m_modo == M_ESPERA) m_modo = M_APUNTAR;
        en_disparo = 1;
    endtask

    task automatic cargar_tablero(input string tag);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) matriz_enemigo[y][x] = 4'(brd[y][x]);
        cargar = 1;
        ciclo();
        cargar = 0;
        modelo_reset();
        m_modo = M_APUNTAR;
        check({tag, "/res"}, 32'(resultado), 32'd0);
        check({tag, "/barco"}, 32'(barco_hundido), 32'd0);
        check({tag, "/game_over"}, 32'(game_over), 32'd0);
        check_cursor(tag);
        check_mapa({tag, "/mapa"});
    endtask

    task automatic barrer(input string tag);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                if (es_barco(brd[y][x]) && shot[y][x] == 0) begin
                    ir_a(x, y);
                    disparo(tag);
                end
    endtask

    task automatic tablero_aleatorio();
        int x0, y0, hor;
        bit libre, colocado;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                brd[y][x] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 15)) : 0;
        for (int id = 5; id >= 1; id--) begin
            colocado = 0;
            for (int t = 0; t < 1000 && !colocado; t++) begin
                hor   = int'($urandom_range(0, 1));
                x0    = hor ? int'($urandom_range(0, 5 - id)) : int'($urandom_range(0, 4));
                y0    = hor ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 5 - id));
                libre = 1;
                for (int k = 0; k < id; k++)
                    if (es_barco(brd[hor ? y0 : y0 + k][hor ? x0 + k : x0])) libre = 0;
                if (libre) begin
                    for (int k = 0; k < id; k++) brd[hor ? y0 : y0 + k][hor ? x0 + k : x0] = id;
                    colocado = 1;
                end
            end
        end
    endtask

    task automatic reset_dut();
        rst_n = 0;
        ciclo();
        ciclo();
        rst_n = 1;
        ciclo();
        modelo_reset();
    endtask

    initial begin
        logic [3:0] b;
        int r;
        rst_n = 0; izquierda = 0; arriba = 0; abajo = 0; derecha = 0;
        disparar = 0; en_disparo = 0; cargar = 0; matriz_enemigo = '0;
        modelo_reset();

        // Reset values and IDLE ignoring every button.
        ciclo();
        check("reset/res", 32'(resultado), 32'd0);
        check("reset/barco", 32'(barco_hundido), 32'd0);
        check("reset/pulsos", 32'({disparo_valido, disparo_repetido, fin_turno}), 32'd0);
        check("reset/game_over", 32'(game_over), 32'd0);
        check_cursor("reset");
        check_mapa("reset/mapa");
        rst_n = 1;
        ciclo();
        en_disparo = 1;
        mover(0, 0, 0, 1);
        mover(0, 0, 1, 0);
        disparo("idle_drop");

        // Fixed board, indexed [y][x]: full fleet of 15 ship cells.
        brd = '{'{1, 0, 3, 3, 3},
                '{0, 0, 0, 0, 0},
                '{5, 5, 5, 5, 5},
                '{2, 2, 0, 0, 9},
                '{4, 4, 4, 4, 0}};
        cargar_tablero("carga_a");

        for (int k = 0; k < 4; k++) mover(0, 0, 0, 1);
        for (int k = 0; k < 4; k++) mover(0, 0, 1, 0);
        disparo("hundido_1");
        disparo("repetido_00");

        for (int k = 0; k < 7; k++) mover(0, 1, 0, 0);
        for (int k = 0; k < 5; k++) mover(1, 0, 0, 0);
        disparo("agua_44");
        mover(0, 0, 0, 1);
        mover(0, 1, 0, 0);
        disparo("espera_drop");
        ceder_turno();

        mover(1, 0, 0, 1);
        mover(0, 1, 1, 0);
        mover(0, 0, 0, 1);
        disparo("disparo_con_abajo", 0, 0, 1, 0);

        for (int x = 0; x < 5; x++) begin
            ir_a(x, 2);
            disparo("barco5");
        end
        barrer("barrido_a");
        check("fin_a/game_over", 32'(game_over), 32'd1);
        disparo("fin_drop");
        mover(0, 0, 0, 1);
        check("fin_a/game_over_hold", 32'(game_over), 32'd1);

        // Reset while the shot is being evaluated: nothing recorded.
        cargar_tablero("carga_b");
        mover(0, 0, 0, 1);
        disparar = 1;
        ciclo();
        disparar = 0;
        rst_n = 0;
        #1;
        modelo_reset();
        check("rst_eval/res", 32'(resultado), 32'd0);
        check("rst_eval/pulsos", 32'({disparo_valido, disparo_repetido, fin_turno}), 32'd0);
        check("rst_eval/game_over", 32'(game_over), 32'd0);
        check_cursor("rst_eval");
        check_mapa("rst_eval/mapa");
        ciclo();
        ciclo();
        rst_n = 1;
        ciclo();
        check("rst_eval/valido_despues", 32'(disparo_valido), 32'd0);
        check_mapa("rst_eval/mapa_despues");
        mover(0, 0, 0, 1);
        cargar_tablero("recarga_b");
        mover(0, 0, 0, 1);
        disparo("tras_reset");
        if (m_modo == M_ESPERA) ceder_turno();

        // Random boards, random play, then clear the rest of the fleet.
        for (int g = 0; g < 4; g++) begin
            tablero_aleatorio();
            cargar_tablero("carga_azar");
            for (int op = 0; op < 250 && m_modo != M_FIN; op++) begin
                r = int'($urandom_range(0, 9));
                b = 4'($urandom_range(0, 15));
                if (r < 5)       mover(b[0], b[1], b[2], b[3]);
                else if (r < 8)  disparo("azar");
                else if (r == 8) disparo("azar_mov", b[0], b[1], b[2], b[3]);
                else begin
                    en_disparo = 0;
                    mover(b[0], b[1], b[2], b[3]);
                    en_disparo = 1;
                end
                if (m_modo == M_ESPERA) begin
                    if (b[0]) mover(b[1], b[2], b[3], b[0]);
                    ceder_turno();
                end
            end
            barrer("barrido_azar");
            check("azar/game_over", 32'(game_over), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
